// File: rtl/pipe_hazard_controller.sv
// Issue-stage hazard controller for the ID->EX->WB pipeline: 2-deep write scoreboard, RAW stall/forward.
// Build option: define FORWARD_EN to resolve RAW hazards by forwarding instead of stalling.

package pipe_hazard_controller_pkg;
  typedef enum logic [3:0] {
    OP_LD   = 4'd0,
    OP_OUT  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_NAND = 4'd4,
    OP_NOR  = 4'd5,
    OP_XOR  = 4'd6,
    OP_SHFL = 4'd7
  } t_opcode;

  localparam logic [1:0] SRC_GPR     = 2'd0;
  localparam logic [1:0] SRC_IMM     = 2'd1;
  localparam logic [1:0] SRC_FWD_WB  = 2'd2;
  localparam logic [1:0] SRC_FWD_RET = 2'd3;
endpackage

module pipe_hazard_controller
  import pipe_hazard_controller_pkg::*;
#(
  parameter int unsigned NUM_GPR = 4,
  parameter int unsigned IDX_W   = (NUM_GPR > 1) ? $clog2(NUM_GPR) : 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             instv,
  output logic             inst_ready,
  input  t_opcode          opcode,
  input  logic [IDX_W-1:0] dst,
  input  logic             src1_imm,
  input  logic [IDX_W-1:0] src1,
  input  logic             src2_imm,
  input  logic [IDX_W-1:0] src2,
  output logic             internal_reset,
  output logic [1:0]       ALUsrc1,
  output logic [1:0]       ALUsrc2,
  output t_opcode          ALUop,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_addr,
  output logic             dataoutv,
  output logic             stalled,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return 32'(idx) < NUM_GPR;
  endfunction

  logic             int_rst_q;
  logic             ex_v_q, ex_v_d, wb_v_q, wb_v_d;
  logic [IDX_W-1:0] ex_idx_q, ex_idx_d, wb_idx_q, wb_idx_d;
  t_opcode          alu_op_q, alu_op_d;
  logic [1:0]       alu_src1_q, alu_src1_d, alu_src2_q, alu_src2_d;
  logic             err_q, err_d;
  logic             out_ex_q, out_ex_d, dataoutv_q, dataoutv_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic is_ld, is_out, is_alu, known, writes, use1, use2, gpr1, gpr2, legal;
  logic m1_ex, m1_wb, m2_ex, m2_wb, raw, hazard, accept;
  logic [1:0] sel1, sel2;

  // Decode and legality of the instruction currently presented
  always_comb begin
    is_ld  = (opcode == OP_LD);
    is_out = (opcode == OP_OUT);
    is_alu = opcode inside {OP_ADD, OP_SUB, OP_NAND, OP_NOR, OP_XOR, OP_SHFL};
    known  = is_ld | is_out | is_alu;
    writes = is_ld | is_alu;
    use1   = is_out | is_alu;
    use2   = is_alu;
    gpr1   = use1 & ~src1_imm;
    gpr2   = use2 & ~src2_imm;
    legal  = known
           & (~is_ld  | src1_imm)
           & (~is_out | ~src1_imm)
           & (~writes | in_range(dst))
           & (~gpr1   | in_range(src1))
           & (~gpr2   | in_range(src2));
  end

  // Source matches against in-flight writes
  always_comb begin
    m1_ex = gpr1 & ex_v_q & (ex_idx_q == src1);
    m1_wb = gpr1 & wb_v_q & (wb_idx_q == src1);
    m2_ex = gpr2 & ex_v_q & (ex_idx_q == src2);
    m2_wb = gpr2 & wb_v_q & (wb_idx_q == src2);
`ifdef FORWARD_EN
    raw   = 1'b0;
`else
    raw   = m1_ex | m1_wb | m2_ex | m2_wb;
`endif
  end

  // Operand selects; the EX entry is younger so it takes priority
  always_comb begin
    sel1 = SRC_GPR;
    sel2 = SRC_GPR;
    if (src1_imm) sel1 = SRC_IMM;
`ifdef FORWARD_EN
    else if (m1_ex) sel1 = SRC_FWD_WB;
    else if (m1_wb) sel1 = SRC_FWD_RET;
`endif
    if (use2 & src2_imm) sel2 = SRC_IMM;
`ifdef FORWARD_EN
    else if (m2_ex) sel2 = SRC_FWD_WB;
    else if (m2_wb) sel2 = SRC_FWD_RET;
`endif
  end

  // Illegal instructions never stall; they are accepted and dropped
  assign hazard     = instv & legal & raw & ~int_rst_q;
  assign inst_ready = ~int_rst_q & ~hazard;
  assign stalled    = hazard;
  assign accept     = instv & inst_ready;

  always_comb begin
    ex_v_d      = 1'b0;
    ex_idx_d    = '0;
    alu_op_d    = OP_LD;
    alu_src1_d  = SRC_GPR;
    alu_src2_d  = SRC_GPR;
    err_d       = 1'b0;
    out_ex_d    = 1'b0;
    wb_v_d      = ex_v_q;
    wb_idx_d    = ex_idx_q;
    dataoutv_d  = out_ex_q;
    stall_cnt_d = stall_cnt_q;
    if (accept) begin
      if (!legal) begin
        err_d = 1'b1;
      end else begin
        alu_op_d   = opcode;
        alu_src1_d = sel1;
        alu_src2_d = sel2;
        ex_v_d     = writes;
        ex_idx_d   = writes ? dst : '0;
        out_ex_d   = is_out;
      end
    end
    if (hazard && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Async reset kills all in-flight controls immediately
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      int_rst_q   <= 1'b1;
      ex_v_q      <= 1'b0;
      ex_idx_q    <= '0;
      wb_v_q      <= 1'b0;
      wb_idx_q    <= '0;
      alu_op_q    <= OP_LD;
      alu_src1_q  <= SRC_GPR;
      alu_src2_q  <= SRC_GPR;
      err_q       <= 1'b0;
      out_ex_q    <= 1'b0;
      dataoutv_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      int_rst_q   <= 1'b0;
      ex_v_q      <= ex_v_d;
      ex_idx_q    <= ex_idx_d;
      wb_v_q      <= wb_v_d;
      wb_idx_q    <= wb_idx_d;
      alu_op_q    <= alu_op_d;
      alu_src1_q  <= alu_src1_d;
      alu_src2_q  <= alu_src2_d;
      err_q       <= err_d;
      out_ex_q    <= out_ex_d;
      dataoutv_q  <= dataoutv_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign internal_reset = int_rst_q;
  assign ALUop          = alu_op_q;
  assign ALUsrc1        = alu_src1_q;
  assign ALUsrc2        = alu_src2_q;
  assign err            = err_q;
  assign wr_en          = wb_v_q;
  assign wr_addr        = wb_idx_q;
  assign dataoutv       = dataoutv_q;
  assign stall_cnt      = stall_cnt_q;

endmodule
